pe_inst_sequencer: RTL and testbench
====================================

# pe_inst_sequencer

Instruction sequencer for a single PE. It latches a layer configuration and a job shape on a start pulse, then issues the PE's 3-bit opcode stream over a valid/ready instruction port. The stream is: psum init, then per-channel weight/ifmap load and MAC, then psum drain, repeated per output row. It sits between the array-level controller and the PE top's `i_inst_*` / `i_layer_*` inputs and drives them directly.

## Interface
Parameters:
- `ROW_CNT_BITWIDTH`, 4: width of row count and row index.
- `CH_CNT_BITWIDTH`, 4: width of channel count.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  job start pulse; sampled only in IDLE.
- `i_abort`  in  1  abort request, level.
- `i_acc_en`  in  1  1: each row starts with ACC_PSUM; 0: each row starts with CLR_PSUM.
- `i_n_row_m1`  in  ROW_CNT_BITWIDTH  number of output rows minus 1.
- `i_n_ch_m1`  in  CH_CNT_BITWIDTH  channels per row minus 1.
- `i_layer_p`, `i_layer_q`, `i_layer_s`  in  5/3/4  layer shape, latched at start.
- `o_layer_p`, `o_layer_q`, `o_layer_s`  out  5/3/4  latched shape, stable for the whole job.
- `o_inst_data`  out  3  opcode.
- `o_inst_valid`  out  1  opcode valid.
- `i_inst_ready`  in  1  PE accepts opcode.
- `o_busy`  out  1  high from the cycle after an accepted start until DONE exits.
- `o_done`  out  1  one-cycle pulse on normal completion.
- `o_row_idx`  out  ROW_CNT_BITWIDTH  current row index.

## Operation
- Opcode encoding:
  - 0 NOP (never issued)
  - 1 LOAD_WGHT
  - 2 LOAD_IFMAP
  - 3 MAC
  - 4 CLR_PSUM
  - 5 ACC_PSUM
  - 6 OUT_PSUM
  - 7 reserved
- States:
  - IDLE
  - PSUM_INIT: issues 5 if the latched acc_en is 1, else 4.
  - WGHT: issues 1.
  - IFMAP: issues 2.
  - MAC: issues 3.
  - OUT: issues 6.
  - DONE
- Transitions:
  - IDLE -> PSUM_INIT on `i_start`. In the same edge, latch acc_en, n_row_m1, n_ch_m1 and the layer p/q/s, and clear the row and channel counters.
  - Every issuing state advances only on handshake (`o_inst_valid & i_inst_ready`).
  - PSUM_INIT -> WGHT -> IFMAP -> MAC.
  - MAC -> WGHT if ch_cnt != n_ch_m1 (ch_cnt+1); else -> OUT (ch_cnt cleared).
  - OUT -> PSUM_INIT if row_cnt != n_row_m1 (row_cnt+1); else -> DONE.
  - DONE -> IDLE unconditionally after 1 cycle.
- Instructions per job: (n_row_m1+1)·(2+3·(n_ch_m1+1)).
- `o_inst_valid` = 1 in every issuing state, 0 in IDLE and DONE. `o_inst_data` is a pure function of state and the latched acc_en.
- Once valid is asserted, valid and data are held until the handshake. Ready may toggle arbitrarily.
- Abort:
  - If `i_abort` is high in an issuing state with valid high and no handshake, finish holding until the handshake, then go to IDLE.
  - If the handshake occurs in the same cycle as abort, go straight to IDLE.
  - An aborted job never pulses `o_done`.
  - Abort in IDLE or DONE has no effect.
- `i_start` outside IDLE is ignored. Start and abort together in IDLE: start wins; abort is then applied at the first handshake.
- `o_row_idx` = row_cnt. It wraps nowhere: counts are bounded by the latched m1 values, so the all-ones m1 value is valid.
- Changing the config inputs mid-job has no effect.

## Timing
- Reset values:
  - state IDLE
  - `o_inst_valid` 0
  - `o_inst_data` 0
  - `o_busy` 0
  - `o_done` 0
  - `o_row_idx` 0
  - `o_layer_*` 0
- Start accepted at edge t: first opcode valid in cycle t+1.
- With ready held high, throughput is 1 opcode per cycle, with no bubbles between rows or channels.
- After the last OUT handshake at edge k: DONE in cycle k+1, with `o_done`=1 and `o_busy`=1. IDLE in cycle k+2, with `o_busy`=0. A new start is accepted at the edge ending cycle k+2.
- Reset asserted mid-job: all outputs go to their reset values immediately (asynchronous). Deassertion is synchronous to `i_clk`.

## Test plan
- n_row_m1=0, n_ch_m1=0, acc_en=0, ready=1, start at edge 0 -> opcodes 4,1,2,3,6 valid in cycles 1..5, `o_done` in cycle 6, `o_busy` low in cycle 7.
- n_row_m1=1, n_ch_m1=2, acc_en=1, ready=1 -> 22 opcodes: [5,1,2,3,1,2,3,1,2,3,6] twice. `o_row_idx` 0 for the first 11 and 1 for the next 11. Done once.
- Same job as scenario 2 with random ready (50%) -> identical opcode sequence. Valid never drops and data never changes while ready=0.
- Abort asserted while MAC is valid and ready=0 for 3 cycles -> MAC held 3 cycles, accepted, then IDLE. No `o_done`. `o_busy` drops.
- Start pulsed while busy, and config inputs changed mid-job -> ignored. `o_layer_*` and the sequence are unchanged.
- Reset asserted during IFMAP of row 1 -> valid/busy 0 immediately. After release, a fresh start reissues from PSUM_INIT with row 0.

Source files
------------

// File: rtl/pe_inst_sequencer.sv
// Instruction sequencer for one PE: latches a job on start, then issues the
// psum-init / load / MAC / drain opcode stream over a valid/ready port.
module pe_inst_sequencer #(
    parameter int ROW_CNT_BITWIDTH = 4,
    parameter int CH_CNT_BITWIDTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_acc_en,
    input  logic [ROW_CNT_BITWIDTH-1:0] i_n_row_m1,
    input  logic [CH_CNT_BITWIDTH-1:0]  i_n_ch_m1,
    input  logic [4:0]                  i_layer_p,
    input  logic [2:0]                  i_layer_q,
    input  logic [3:0]                  i_layer_s,
    output logic [4:0]                  o_layer_p,
    output logic [2:0]                  o_layer_q,
    output logic [3:0]                  o_layer_s,
    output logic [2:0]                  o_inst_data,
    output logic                        o_inst_valid,
    input  logic                        i_inst_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [ROW_CNT_BITWIDTH-1:0] o_row_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PSUM_INIT,
        S_WGHT,
        S_IFMAP,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_LOAD_WGHT  = 3'd1;
    localparam logic [2:0] OP_LOAD_IFMAP = 3'd2;
    localparam logic [2:0] OP_MAC        = 3'd3;
    localparam logic [2:0] OP_CLR_PSUM   = 3'd4;
    localparam logic [2:0] OP_ACC_PSUM   = 3'd5;
    localparam logic [2:0] OP_OUT_PSUM   = 3'd6;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_acc_en;
    logic                        r_abort_pend;
    logic [ROW_CNT_BITWIDTH-1:0] r_n_row_m1;
    logic [ROW_CNT_BITWIDTH-1:0] r_row_cnt;
    logic [CH_CNT_BITWIDTH-1:0]  r_n_ch_m1;
    logic [CH_CNT_BITWIDTH-1:0]  r_ch_cnt;
    logic [4:0]                  r_layer_p;
    logic [2:0]                  r_layer_q;
    logic [3:0]                  r_layer_s;
    logic                        w_issuing;
    logic                        w_hs;
    logic                        w_abort;
    logic                        w_last_ch;
    logic                        w_last_row;

    assign w_issuing  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_hs       = w_issuing && i_inst_ready;
    // An abort seen while stalled is remembered so it still applies at the handshake.
    assign w_abort    = i_abort || r_abort_pend;
    assign w_last_ch  = (r_ch_cnt == r_n_ch_m1);
    assign w_last_row = (r_row_cnt == r_n_row_m1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_inst_data = OP_NOP;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_PSUM_INIT;
            end
            S_PSUM_INIT: begin
                o_inst_data = r_acc_en ? OP_ACC_PSUM : OP_CLR_PSUM;
                if (w_hs) w_state_nxt = w_abort ? S_IDLE : S_WGHT;
            end
            S_WGHT: begin
                o_inst_data = OP_LOAD_WGHT;
                if (w_hs) w_state_nxt = w_abort ? S_IDLE : S_IFMAP;
            end
            S_IFMAP: begin
                o_inst_data = OP_LOAD_IFMAP;
                if (w_hs) w_state_nxt = w_abort ? S_IDLE : S_MAC;
            end
            S_MAC: begin
                o_inst_data = OP_MAC;
                if (w_hs) begin
                    if (w_abort)        w_state_nxt = S_IDLE;
                    else if (w_last_ch) w_state_nxt = S_OUT;
                    else                w_state_nxt = S_WGHT;
                end
            end
            S_OUT: begin
                o_inst_data = OP_OUT_PSUM;
                if (w_hs) begin
                    if (w_abort)         w_state_nxt = S_IDLE;
                    else if (w_last_row) w_state_nxt = S_DONE;
                    else                 w_state_nxt = S_PSUM_INIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc_en     <= 1'b0;
            r_abort_pend <= 1'b0;
            r_n_row_m1   <= '0;
            r_n_ch_m1    <= '0;
            r_row_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_layer_p    <= '0;
            r_layer_q    <= '0;
            r_layer_s    <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_acc_en     <= i_acc_en;
                r_abort_pend <= i_abort;
                r_n_row_m1   <= i_n_row_m1;
                r_n_ch_m1    <= i_n_ch_m1;
                r_row_cnt    <= '0;
                r_ch_cnt     <= '0;
                r_layer_p    <= i_layer_p;
                r_layer_q    <= i_layer_q;
                r_layer_s    <= i_layer_s;
            end
        end else if (w_issuing) begin
            if (w_hs) begin
                if (w_abort) begin
                    r_abort_pend <= 1'b0;
                end else if (r_state == S_MAC) begin
                    r_ch_cnt <= w_last_ch ? '0 : r_ch_cnt + 1'b1;
                end else if ((r_state == S_OUT) && !w_last_row) begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
            end else if (i_abort) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign o_inst_valid = w_issuing;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_row_idx    = r_row_cnt;
    assign o_layer_p    = r_layer_p;
    assign o_layer_q    = r_layer_q;
    assign o_layer_s    = r_layer_s;

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Directed bench for pe_inst_sequencer: table of jobs checked against an
// opcode-sequence model, plus abort, start+abort and mid-job reset sequences.
module tb_pe_inst_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_abort;
    logic       i_acc_en;
    logic [3:0] i_n_row_m1;
    logic [3:0] i_n_ch_m1;
    logic [4:0] i_layer_p;
    logic [2:0] i_layer_q;
    logic [3:0] i_layer_s;
    logic [4:0] o_layer_p;
    logic [2:0] o_layer_q;
    logic [3:0] o_layer_s;
    logic [2:0] o_inst_data;
    logic       o_inst_valid;
    logic       i_inst_ready;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_row_idx;

    int checks = 0;
    int errors = 0;

    pe_inst_sequencer #(
        .ROW_CNT_BITWIDTH(4),
        .CH_CNT_BITWIDTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_acc_en    (i_acc_en),
        .i_n_row_m1  (i_n_row_m1),
        .i_n_ch_m1   (i_n_ch_m1),
        .i_layer_p   (i_layer_p),
        .i_layer_q   (i_layer_q),
        .i_layer_s   (i_layer_s),
        .o_layer_p   (o_layer_p),
        .o_layer_q   (o_layer_q),
        .o_layer_s   (o_layer_s),
        .o_inst_data (o_inst_data),
        .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_row_idx   (o_row_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit acc;
        int n_row;
        int n_ch;
        int p;
        int q;
        int s;
        bit rnd;
        bit mid;
        int exp_cnt;
    } job_t;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_job(input job_t j, input string tag);
        int exp_op[$];
        int exp_row[$];
        int cyc;
        int nhs;
        int last_hs;
        bit hold;
        bit rdy;
        bit got_done;
        int held;
        for (int r = 0; r <= j.n_row; r++) begin
            exp_op.push_back(j.acc ? 5 : 4);
            exp_row.push_back(r);
            for (int c = 0; c <= j.n_ch; c++) begin
                exp_op.push_back(1); exp_row.push_back(r);
                exp_op.push_back(2); exp_row.push_back(r);
                exp_op.push_back(3); exp_row.push_back(r);
            end
            exp_op.push_back(6);
            exp_row.push_back(r);
        end
        i_acc_en     = j.acc;
        i_n_row_m1   = 4'(j.n_row);
        i_n_ch_m1    = 4'(j.n_ch);
        i_layer_p    = 5'(j.p);
        i_layer_q    = 3'(j.q);
        i_layer_s    = 4'(j.s);
        i_inst_ready = 1'b1;
        i_start      = 1'b1;
        cyc = 0; nhs = 0; last_hs = 0; hold = 0; held = 0; got_done = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) i_start = 1'b0;
            if (j.mid && cyc == 2) begin
                i_start    = 1'b1;
                i_acc_en   = ~j.acc;
                i_n_row_m1 = 4'd5;
                i_n_ch_m1  = 4'd3;
                i_layer_p  = 5'd1;
                i_layer_q  = 3'd1;
                i_layer_s  = 4'd1;
            end
            if (j.mid && cyc == 3) i_start = 1'b0;
            if (o_done) begin
                got_done = 1;
                break;
            end
            if (cyc == 1) chk({tag, "_busy_first"}, int'(o_busy), 1);
            chk({tag, "_valid"}, int'(o_inst_valid), 1);
            if (!o_inst_valid) break;
            if (hold) chk({tag, "_hold_data"}, int'(o_inst_data), held);
            rdy = j.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_inst_ready = rdy;
            if (rdy) begin
                if (nhs < exp_op.size()) begin
                    chk($sformatf("%s_op%0d", tag, nhs), int'(o_inst_data), exp_op[nhs]);
                    chk($sformatf("%s_row%0d", tag, nhs), int'(o_row_idx), exp_row[nhs]);
                end
                nhs++;
                last_hs = cyc;
                hold = 0;
            end else begin
                hold = 1;
                held = int'(o_inst_data);
            end
        end
        chk({tag, "_done_seen"}, int'(got_done), 1);
        chk({tag, "_n_inst"}, nhs, j.exp_cnt);
        chk({tag, "_done_latency"}, cyc - last_hs, 1);
        chk({tag, "_done_busy"}, int'(o_busy), 1);
        chk({tag, "_done_valid"}, int'(o_inst_valid), 0);
        chk({tag, "_layer_p"}, int'(o_layer_p), j.p);
        chk({tag, "_layer_q"}, int'(o_layer_q), j.q);
        chk({tag, "_layer_s"}, int'(o_layer_s), j.s);
        i_inst_ready = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk({tag, "_idle_done"}, int'(o_done), 0);
        chk({tag, "_idle_busy"}, int'(o_busy), 0);
        chk({tag, "_idle_valid"}, int'(o_inst_valid), 0);
    endtask

    job_t jobs[6];

    initial begin
        jobs[0] = '{acc: 0, n_row: 0,  n_ch: 0,  p: 3,  q: 2, s: 5,  rnd: 0, mid: 0, exp_cnt: 5};
        jobs[1] = '{acc: 1, n_row: 1,  n_ch: 2,  p: 17, q: 5, s: 9,  rnd: 0, mid: 0, exp_cnt: 22};
        jobs[2] = '{acc: 1, n_row: 1,  n_ch: 2,  p: 17, q: 5, s: 9,  rnd: 1, mid: 0, exp_cnt: 22};
        jobs[3] = '{acc: 0, n_row: 0,  n_ch: 1,  p: 31, q: 7, s: 15, rnd: 0, mid: 1, exp_cnt: 8};
        jobs[4] = '{acc: 1, n_row: 15, n_ch: 15, p: 8,  q: 4, s: 2,  rnd: 0, mid: 0, exp_cnt: 800};
        jobs[5] = '{acc: 0, n_row: 2,  n_ch: 0,  p: 12, q: 3, s: 7,  rnd: 1, mid: 0, exp_cnt: 15};

        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_acc_en = 1'b0;
        i_n_row_m1 = '0; i_n_ch_m1 = '0; i_layer_p = '0; i_layer_q = '0; i_layer_s = '0;
        i_inst_ready = 1'b0;
        #2;
        chk("rst_valid", int'(o_inst_valid), 0);
        chk("rst_data", int'(o_inst_data), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_row", int'(o_row_idx), 0);
        chk("rst_layer_p", int'(o_layer_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_job(jobs[k], $sformatf("job%0d", k));

        // Abort while MAC is stalled: abort pulsed once, MAC held 3 cycles, then accepted.
        i_acc_en = 1'b0; i_n_row_m1 = 4'd1; i_n_ch_m1 = 4'd1;
        i_inst_ready = 1'b1; i_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_inst_valid && o_inst_data == 3'd3) break;
        end
        chk("abort_mac_reached", int'(o_inst_data), 3);
        i_inst_ready = 1'b0;
        i_abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_abort = 1'b0;
            chk("abort_hold_valid", int'(o_inst_valid), 1);
            chk("abort_hold_data", int'(o_inst_data), 3);
        end
        i_inst_ready = 1'b1;
        @(negedge clk);
        chk("abort_valid", int'(o_inst_valid), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        @(negedge clk);
        chk("abort_done_after", int'(o_done), 0);
        chk("abort_busy_after", int'(o_busy), 0);

        // Start and abort together: the first opcode is issued, then back to IDLE.
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        chk("startabort_valid", int'(o_inst_valid), 1);
        chk("startabort_data", int'(o_inst_data), 4);
        @(negedge clk);
        chk("startabort_idle_valid", int'(o_inst_valid), 0);
        chk("startabort_idle_busy", int'(o_busy), 0);
        chk("startabort_no_done", int'(o_done), 0);

        // Reset during IFMAP of row 1, then a fresh job.
        i_acc_en = 1'b1; i_n_row_m1 = 4'd1; i_n_ch_m1 = 4'd0;
        i_layer_p = 5'd9; i_layer_q = 3'd6; i_layer_s = 4'd3;
        i_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_row_idx == 4'd1 && o_inst_data == 3'd2) break;
        end
        chk("rstmid_row1_ifmap", int'(o_inst_data), 2);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", int'(o_inst_valid), 0);
        chk("rstmid_busy", int'(o_busy), 0);
        chk("rstmid_data", int'(o_inst_data), 0);
        chk("rstmid_row", int'(o_row_idx), 0);
        chk("rstmid_layer_p", int'(o_layer_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job('{acc: 1, n_row: 1, n_ch: 0, p: 9, q: 6, s: 3, rnd: 0, mid: 0, exp_cnt: 10}, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
